// File: rtl/matmul_z_unloader_if.sv
// Signal bundle joining the Z unloader to the multiplier control, the Z BRAM read port and the consumer.
// master = unloader side; slave = environment side (multiplier, BRAM, downstream sink).
interface matmul_z_unloader_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
);
   logic                  start;
   logic                  busy;
   logic                  done;
   logic [ADDR_WIDTH-1:0] z_addr;
   logic                  z_rd_en;
   logic [DATA_WIDTH-1:0] z_dout;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_last;
   logic                  out_frame_last;

   modport master (
      input  start, z_dout, out_ready,
      output busy, done, z_addr, z_rd_en, out_data, out_valid, out_last, out_frame_last
   );

   modport slave (
      output start, z_dout, out_ready,
      input  busy, done, z_addr, z_rd_en, out_data, out_valid, out_last, out_frame_last
   );
endinterface

// File: rtl/matmul_z_unloader.sv
// Streams the VECTOR_SIZE^2 Z matrix row-major: first word 3 cycles after start, then 1/cycle.
// A 2-entry buffer absorbs BRAM latency; issue stalls under backpressure, never more than 2 words held.
module matmul_z_unloader #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 6,
   parameter int VECTOR_SIZE = 8
) (
   input  logic                i_clock,
   input  logic                i_reset,
   matmul_z_unloader_if.master bus
);
   localparam int N  = VECTOR_SIZE * VECTOR_SIZE;
   localparam int CW = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);
   localparam logic [CW-1:0]         LAST_COL  = CW'(VECTOR_SIZE - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic                  r_inflight;
   logic [DATA_WIDTH-1:0] r_mem [0:1];
   logic                  r_wr_sel;
   logic                  r_rd_sel;
   logic [1:0]            r_count;
   logic [ADDR_WIDTH-1:0] r_out_idx;
   logic [CW-1:0]         r_out_col;

   logic                  w_issue;
   logic                  w_done;
   logic                  w_start_acc;
   logic                  w_vld;
   logic                  w_pop;
   logic [2:0]            w_occ;

   assign w_vld = (r_count != 2'd0);
   assign w_pop = w_vld && bus.out_ready;
   assign w_occ = {1'b0, r_count} + {2'b00, r_inflight};

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_issue      = 1'b0;
      w_done       = 1'b0;
      w_start_acc  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_start_acc  = 1'b1;
               w_next_state = S_READ;
            end
         end
         S_READ: begin
            // Occupancy counts the word already on its way back from the BRAM.
            if (w_occ < (3'd2 + {2'b00, w_pop})) begin
               w_issue = 1'b1;
               if (r_rd_ptr == LAST_ADDR) begin
                  w_next_state = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if ((r_count == 2'd0) && !r_inflight) begin
               w_done       = 1'b1;
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_rd_ptr   <= '0;
         r_inflight <= 1'b0;
         r_mem[0]   <= '0;
         r_mem[1]   <= '0;
         r_wr_sel   <= 1'b0;
         r_rd_sel   <= 1'b0;
         r_count    <= 2'd0;
         r_out_idx  <= '0;
         r_out_col  <= '0;
      end else begin
         r_inflight <= w_issue;

         if (w_start_acc) begin
            r_rd_ptr <= '0;
         end else if (w_issue && (r_rd_ptr != LAST_ADDR)) begin
            r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
         end

         // BRAM data lands one cycle after the issue that requested it.
         if (r_inflight) begin
            r_mem[r_wr_sel] <= bus.z_dout;
            r_wr_sel        <= ~r_wr_sel;
         end
         if (w_pop) begin
            r_rd_sel <= ~r_rd_sel;
         end
         r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};

         if (w_start_acc) begin
            r_out_idx <= '0;
            r_out_col <= '0;
         end else if (w_pop) begin
            r_out_idx <= r_out_idx + ADDR_WIDTH'(1);
            r_out_col <= (r_out_col == LAST_COL) ? '0 : (r_out_col + CW'(1));
         end
      end
   end

   assign bus.z_rd_en        = w_issue;
   assign bus.z_addr         = w_issue ? r_rd_ptr : '0;
   assign bus.out_valid      = w_vld;
   assign bus.out_data       = w_vld ? r_mem[r_rd_sel] : '0;
   assign bus.out_last       = w_vld && (r_out_col == LAST_COL);
   assign bus.out_frame_last = w_vld && (r_out_idx == LAST_ADDR);
   assign bus.busy           = (r_state != S_IDLE) && !w_done;
   assign bus.done           = w_done;
endmodule

// File: tb/tb_matmul_z_unloader.sv
// Directed bench for the Z unloader: BRAM model z[a]=3a+1 and a cycle-level occupancy model.
module tb_matmul_z_unloader;
   localparam int DW = 32;
   localparam int AW = 6;
   localparam int VS = 8;
   localparam int N  = VS * VS;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   matmul_z_unloader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

   matmul_z_unloader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VECTOR_SIZE(VS)) dut (
      .i_clock (clock),
      .i_reset (reset),
      .bus     (bus)
   );

   logic [DW-1:0] zmem [0:N-1];
   initial begin
      for (int a = 0; a < N; a++) zmem[a] = DW'(a * 3 + 1);
   end
   always @(posedge clock) begin
      if (bus.z_rd_en) bus.z_dout <= zmem[bus.z_addr];
   end

   int  n_total = 0;
   int  n_bad   = 0;
   time t0      = 0;

   int n_xfer, exp_idx, n_done, n_busy, n_issue, m_addr;
   int first_x, last_x, done_cyc, busy_first, busy_last;
   int m_count = 0;
   int m_inflight = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic          prev_last, prev_flast;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic clr();
      n_xfer = 0; exp_idx = 0; n_done = 0; n_busy = 0; n_issue = 0; m_addr = 0;
      first_x = -1; last_x = -1; done_cyc = -1; busy_first = -1; busy_last = -1;
   endtask

   // Per-cycle observer: samples mid-cycle, then advances the occupancy model.
   always @(negedge clock) begin
      int rel;
      int pop;
      if (reset) begin
         m_count = 0; m_inflight = 0; prev_stall = 1'b0;
      end else begin
         rel = int'(($time - t0 + 5) / 10);
         pop = int'(bus.out_valid && bus.out_ready);
         chk("vld", bus.out_valid, m_count != 0);
         if (prev_stall) begin
            chk("hold_data", bus.out_data, prev_data);
            chk("hold_last", bus.out_last, prev_last);
            chk("hold_flast", bus.out_frame_last, prev_flast);
         end
         if (bus.z_rd_en) begin
            n_issue++;
            chk("addr", bus.z_addr, m_addr);
            chk("occ", (m_count + m_inflight - pop) < 2, 1);
            m_addr++;
         end
         if (pop != 0) begin
            chk("data", bus.out_data, exp_idx * 3 + 1);
            chk("last", bus.out_last, (exp_idx % VS) == VS - 1);
            chk("flast", bus.out_frame_last, exp_idx == N - 1);
            if (first_x < 0) first_x = rel;
            last_x = rel;
            exp_idx++;
            n_xfer++;
         end
         if (bus.busy) begin
            n_busy++;
            if (busy_first < 0) busy_first = rel;
            busy_last = rel;
         end
         if (bus.done) begin
            n_done++;
            done_cyc = rel;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
         prev_last  = bus.out_last;
         prev_flast = bus.out_frame_last;
         m_count    = m_count + m_inflight - pop;
         m_inflight = int'(bus.z_rd_en);
      end
   end

   // Start is sampled at the next edge, which becomes cycle-0 of the frame.
   task automatic do_start();
      bus.start = 1'b1;
      @(posedge clock);
      t0 = $time;
      clr();
      #1 bus.start = 1'b0;
   endtask

   // mode 0: ready high; 1: ready 1,0,0,1; 2: ready low 20 cycles; 3: start re-pulses; 4: back-to-back start
   task automatic run_frame(input int mode);
      for (int c = 1; c <= 400; c++) begin
         case (mode)
            1: bus.out_ready = ((c % 4) == 1) || ((c % 4) == 0);
            2: begin
               bus.out_ready = (c > 20);
               if (c == 21) begin
                  chk("bp_issues", n_issue, 2);
                  chk("bp_vld", bus.out_valid, 1);
                  chk("bp_data", bus.out_data, 1);
               end
            end
            3: begin
               bus.out_ready = 1'b1;
               bus.start = (c == 10) || (c == 30);
            end
            4: begin
               bus.out_ready = 1'b1;
               bus.start = (c == 67);
            end
            default: bus.out_ready = 1'b1;
         endcase
         @(posedge clock);
         #1;
         if (n_done > 0) break;
      end
      if (mode != 4) bus.start = 1'b0;
      chk("done_seen", n_done > 0, 1);
   endtask

   task automatic finish_frame(input string tag);
      repeat (5) @(posedge clock);
      #1;
      chk({tag, "_xfers"}, n_xfer, N);
      chk({tag, "_dones"}, n_done, 1);
      chk({tag, "_issues"}, n_issue, N);
      chk({tag, "_busy_end"}, bus.busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clr();
      bus.start = 1'b0;
      bus.out_ready = 1'b0;
      #12;
      chk("rst_vld", bus.out_valid, 0);
      chk("rst_data", bus.out_data, 0);
      chk("rst_last", bus.out_last, 0);
      chk("rst_flast", bus.out_frame_last, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_rden", bus.z_rd_en, 0);
      chk("rst_addr", bus.z_addr, 0);
      @(posedge clock);
      #1 reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;

      // Free-running frame with exact cycle positions
      bus.out_ready = 1'b1;
      do_start();
      run_frame(0);
      finish_frame("t1");
      chk("t1_first", first_x, 3);
      chk("t1_lastx", last_x, 66);
      chk("t1_donecyc", done_cyc, 67);
      chk("t1_busy_first", busy_first, 1);
      chk("t1_busy_last", busy_last, 66);
      chk("t1_busy_cnt", n_busy, 66);

      // Ready toggling 1,0,0,1
      do_start();
      run_frame(1);
      finish_frame("t2");

      // Ready held low for 20 cycles
      bus.out_ready = 1'b0;
      do_start();
      run_frame(2);
      finish_frame("t3");

      // Start re-pulsed mid-unload
      do_start();
      run_frame(3);
      finish_frame("t4");

      // Async reset mid-unload with buffer full
      bus.out_ready = 1'b1;
      do_start();
      for (int c = 0; c < 200; c++) begin
         if (n_xfer >= 20) break;
         @(posedge clock);
         #1;
      end
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clock);
      #3;
      chk("t5_pre_vld", bus.out_valid, 1);
      chk("t5_pre_xfers", n_xfer, 20);
      reset = 1'b1;
      #1;
      chk("t5_vld", bus.out_valid, 0);
      chk("t5_data", bus.out_data, 0);
      chk("t5_last", bus.out_last, 0);
      chk("t5_flast", bus.out_frame_last, 0);
      chk("t5_busy", bus.busy, 0);
      chk("t5_done", bus.done, 0);
      chk("t5_rden", bus.z_rd_en, 0);
      chk("t5_addr", bus.z_addr, 0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(posedge clock);
      #1 bus.out_ready = 1'b1;
      do_start();
      run_frame(0);
      finish_frame("t5");
      chk("t5_first", first_x, 3);

      // Back-to-back: start during the done cycle is ignored, the next cycle is taken
      do_start();
      run_frame(4);
      chk("t6a_xfers", n_xfer, N);
      chk("t6a_dones", n_done, 1);
      chk("t6a_donecyc", done_cyc, 67);
      @(negedge clock);
      chk("t6_idle_busy", bus.busy, 0);
      do_start();
      run_frame(0);
      finish_frame("t6b");
      chk("t6b_first", first_x, 3);
      chk("t6b_donecyc", done_cyc, 67);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
